// File: rtl/mac8_row_accumulator.sv
// mac8_row_accumulator
//
// Row dot-product engine that sits behind the 8-wide address counter. Every
// accepted beat carries 8 signed operand pairs. The pairs are multiplied lane
// by lane, the 8 products are reduced to one sum, and the sums are accumulated
// over ROW_BEATS beats. Each finished row is presented with its row index on a
// valid/ready output that supports full backpressure.
//
// Pipeline: P (products) -> S (lane sum) -> A (accumulate) -> output register.
// All stages advance together when adv = !out_valid || out_ready.
//
// Optional build macro:
//   MAC8_SATURATE_EN  When defined, an out-of-range accumulation clamps to the
//                     signed ACC_W limit and stays clamped until the next row.
//                     When undefined, the accumulator wraps modulo 2^ACC_W.
//                     ovf is set in both builds.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     a_data/b_data hold one beat
//   in_ready     beat is taken when in_valid && in_ready
//   a_data       lane k in bits [k*DATA_W +: DATA_W], signed
//   b_data       same packing as a_data
//   out_valid    out_data holds a finished row sum
//   out_ready    consumer takes the row when out_valid && out_ready
//   out_data     signed row dot-product
//   out_row_idx  index of the row in out_data, wraps modulo 2^ROW_IDX_W
//   ovf          sticky: an accumulation left the signed ACC_W range

module mac8_row_accumulator #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned ROW_BEATS = 16,
  parameter int unsigned ROW_IDX_W = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*DATA_W-1:0]        a_data,
  input  logic [8*DATA_W-1:0]        b_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_data,
  output logic [ROW_IDX_W-1:0]       out_row_idx,
  output logic                       ovf
);

  localparam int          Lanes = 8;
  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned SumW  = ProdW + 3;
  // Wide enough to hold acc + sum without losing the true value.
  localparam int unsigned FullW = ((ACC_W > SumW) ? ACC_W : SumW) + 1;
  localparam int unsigned BeatW = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(ROW_BEATS - 1);

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [FullW-1:0] AccMaxFull =
      {{(FullW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [FullW-1:0] AccMinFull =
      {{(FullW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic adv;
  logic accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Beat position within the current row.
  logic [BeatW-1:0] beat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
    end else if (accept) begin
      beat_q <= (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
    end
  end

  // Stage P: lane products.
  logic signed [ProdW-1:0] a_ext  [Lanes];
  logic signed [ProdW-1:0] b_ext  [Lanes];
  logic signed [ProdW-1:0] prod_d [Lanes];
  logic signed [ProdW-1:0] prod_q [Lanes];
  logic                    vp_q;
  logic                    first_p_q;
  logic                    last_p_q;

  always_comb begin
    for (int k = 0; k < Lanes; k++) begin
      a_ext[k]  = {{DATA_W{a_data[k*DATA_W + DATA_W - 1]}}, a_data[k*DATA_W +: DATA_W]};
      b_ext[k]  = {{DATA_W{b_data[k*DATA_W + DATA_W - 1]}}, b_data[k*DATA_W +: DATA_W]};
      // Operands are sign-extended to ProdW, so the low ProdW bits are exact.
      prod_d[k] = a_ext[k] * b_ext[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vp_q      <= 1'b0;
      first_p_q <= 1'b0;
      last_p_q  <= 1'b0;
      for (int k = 0; k < Lanes; k++) begin
        prod_q[k] <= '0;
      end
    end else if (adv) begin
      vp_q      <= in_valid;
      first_p_q <= (beat_q == '0);
      last_p_q  <= (beat_q == LastBeat);
      if (in_valid) begin
        for (int k = 0; k < Lanes; k++) begin
          prod_q[k] <= prod_d[k];
        end
      end
    end
  end

  // Stage S: reduce the 8 products; 3 guard bits cover the 8-way sum.
  logic signed [SumW-1:0] sum_d;
  logic signed [SumW-1:0] sum_q;
  logic                   vs_q;
  logic                   first_s_q;
  logic                   last_s_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < Lanes; k++) begin
      sum_d = sum_d + {{3{prod_q[k][ProdW-1]}}, prod_q[k]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q      <= 1'b0;
      first_s_q <= 1'b0;
      last_s_q  <= 1'b0;
      sum_q     <= '0;
    end else if (adv) begin
      vs_q      <= vp_q;
      first_s_q <= first_p_q;
      last_s_q  <= last_p_q;
      if (vp_q) begin
        sum_q <= sum_d;
      end
    end
  end

  // Stage A: accumulate with range check on the full-precision sum.
  logic signed [FullW-1:0] acc_ext;
  logic signed [FullW-1:0] sum_ext;
  logic signed [FullW-1:0] full_sum;
  logic                    over_hi;
  logic                    over_lo;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;
  logic                    va_q;
  logic                    last_a_q;
  logic                    ovf_q;
`ifdef MAC8_SATURATE_EN
  logic                    sat_d;
  logic                    sat_q;
`endif

  always_comb begin
    acc_ext = {{(FullW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    if (first_s_q) begin
      acc_ext = '0;
    end
    sum_ext  = {{(FullW-SumW){sum_q[SumW-1]}}, sum_q};
    full_sum = acc_ext + sum_ext;
    over_hi  = full_sum > AccMaxFull;
    over_lo  = full_sum < AccMinFull;
    acc_d    = full_sum[ACC_W-1:0];
`ifdef MAC8_SATURATE_EN
    sat_d = sat_q;
    if (sat_q && !first_s_q) begin
      // Once clamped, the row result stays pinned at the limit.
      acc_d = acc_q;
    end else if (over_hi) begin
      acc_d = AccMax;
      sat_d = 1'b1;
    end else if (over_lo) begin
      acc_d = AccMin;
      sat_d = 1'b1;
    end else begin
      sat_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      va_q     <= 1'b0;
      last_a_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef MAC8_SATURATE_EN
      sat_q    <= 1'b0;
`endif
    end else if (adv) begin
      va_q     <= vs_q;
      last_a_q <= last_s_q;
      if (vs_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | over_hi | over_lo;
`ifdef MAC8_SATURATE_EN
        sat_q <= sat_d;
`endif
      end
    end
  end

  assign ovf = ovf_q;

  // Output register: a completing row overwrites even during a handshake.
  logic [ROW_IDX_W-1:0] row_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row_idx <= '0;
      row_q       <= '0;
    end else if (adv) begin
      if (va_q && last_a_q) begin
        out_valid   <= 1'b1;
        out_data    <= acc_q;
        out_row_idx <= row_q;
        row_q       <= row_q + ROW_IDX_W'(1);
      end else begin
        out_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac8_row_accumulator.sv
// Self-checking bench for mac8_row_accumulator. A row-level reference model
// sums a*b over every accepted beat with plain integer arithmetic; emitted rows
// are captured on each output handshake and compared against it.

module tb_mac8_row_accumulator;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned ROW_BEATS = 16;
  localparam int unsigned ROW_IDX_W = 7;
  localparam int unsigned OVF_ACC_W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic [8*DATA_W-1:0]        a_data;
  logic [8*DATA_W-1:0]        b_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    out_data;
  logic [ROW_IDX_W-1:0]       out_row_idx;
  logic                       ovf;

  // Second instance with a narrow accumulator for the overflow scenario.
  logic                       o_in_valid;
  logic                       o_in_ready;
  logic [8*DATA_W-1:0]        o_a_data;
  logic [8*DATA_W-1:0]        o_b_data;
  logic                       o_out_valid;
  logic                       o_out_ready;
  logic signed [OVF_ACC_W-1:0] o_out_data;
  logic [ROW_IDX_W-1:0]       o_out_row_idx;
  logic                       o_ovf;

  mac8_row_accumulator #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .ROW_BEATS(ROW_BEATS),
    .ROW_IDX_W(ROW_IDX_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_data     (a_data),
    .b_data     (b_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row_idx(out_row_idx),
    .ovf        (ovf)
  );

  mac8_row_accumulator #(
    .DATA_W   (DATA_W),
    .ACC_W    (OVF_ACC_W),
    .ROW_BEATS(ROW_BEATS),
    .ROW_IDX_W(ROW_IDX_W)
  ) dut_ovf (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (o_in_valid),
    .in_ready   (o_in_ready),
    .a_data     (o_a_data),
    .b_data     (o_b_data),
    .out_valid  (o_out_valid),
    .out_ready  (o_out_ready),
    .out_data   (o_out_data),
    .out_row_idx(o_out_row_idx),
    .ovf        (o_ovf)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  longint row_acc;
  int     row_beats;
  int     row_n;
  int     cyc;
  int     last_accept_cyc;
  longint exp_data[$];
  int     exp_idx[$];
  longint got_data[$];
  int     got_idx[$];
  int     got_cyc[$];

  function automatic longint dot8(input logic [8*DATA_W-1:0] a, input logic [8*DATA_W-1:0] b);
    longint s = 0;
    for (int k = 0; k < 8; k++) begin
      s += longint'($signed(a[k*DATA_W +: DATA_W])) * longint'($signed(b[k*DATA_W +: DATA_W]));
    end
    return s;
  endfunction

  function automatic int accepted_beats();
    return row_n * ROW_BEATS + row_beats;
  endfunction

  task automatic model_reset();
    row_acc   = 0;
    row_beats = 0;
    row_n     = 0;
    cyc       = 0;
    last_accept_cyc = -1;
    exp_data.delete();
    exp_idx.delete();
    got_data.delete();
    got_idx.delete();
    got_cyc.delete();
  endtask

  task automatic rand_ops();
    for (int k = 0; k < 8; k++) begin
      a_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      b_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  // Called at a negedge after inputs are set: record handshakes, advance a cycle.
  task automatic step();
    #1;
    if (in_valid && in_ready) begin
      row_acc += dot8(a_data, b_data);
      row_beats++;
      last_accept_cyc = cyc;
      if (row_beats == ROW_BEATS) begin
        exp_data.push_back(row_acc);
        exp_idx.push_back(row_n % (1 << ROW_IDX_W));
        row_n++;
        row_acc   = 0;
        row_beats = 0;
      end
    end
    if (out_valid && out_ready) begin
      got_data.push_back(longint'(out_data));
      got_idx.push_back(int'(out_row_idx));
      got_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a_data      = '0;
    b_data      = '0;
    o_in_valid  = 1'b0;
    o_out_ready = 1'b1;
    o_a_data    = '0;
    o_b_data    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic drain(input int n_rows, input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < budget && got_data.size() < n_rows; c++) begin
      step();
    end
    total++;
    if (got_data.size() < n_rows) begin
      bad++;
      $display("FAIL drain_rows: got %0d rows, required %0d", got_data.size(), n_rows);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a_data    = '1;
    b_data    = '1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
    total++; if (out_row_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d, required 0", out_row_idx); end
    total++; if (ovf !== 1'b0 || o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b/%b, required 0/0", ovf, o_ovf); end
    apply_reset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    apply_reset();
    for (int i = 0; i < ROW_BEATS; i++) begin
      in_valid = 1'b1;
      a_data   = {8{DATA_W'(1)}};
      b_data   = {8{DATA_W'(2)}};
      step();
    end
    drain(1, 20);
    if (got_data.size() >= 1) begin
      total++; if (got_data[0] != 256) begin bad++; $display("FAIL basic_sum: got %0d, required 256", got_data[0]); end
      total++; if (got_data[0] != exp_data[0]) begin bad++; $display("FAIL basic_model: got %0d, required %0d", got_data[0], exp_data[0]); end
      total++; if (got_idx[0] != 0) begin bad++; $display("FAIL basic_idx: got %0d, required 0", got_idx[0]); end
      // got_cyc is the cycle after the edge where out_valid first rose.
      total++; if (got_cyc[0] - 1 - last_accept_cyc != 3) begin bad++; $display("FAIL basic_latency: got %0d, required 3", got_cyc[0] - 1 - last_accept_cyc); end
    end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b, required 0", ovf); end
  endtask

  task automatic test_signed();
    apply_reset();
    for (int i = 0; i < ROW_BEATS; i++) begin
      in_valid = 1'b1;
      a_data   = {8{8'h80}};
      b_data   = {8{8'h7f}};
      step();
    end
    drain(1, 20);
    if (got_data.size() >= 1) begin
      total++; if (got_data[0] != -2080768) begin bad++; $display("FAIL signed_sum: got %0d, required -2080768", got_data[0]); end
      total++; if (got_data[0] != exp_data[0]) begin bad++; $display("FAIL signed_model: got %0d, required %0d", got_data[0], exp_data[0]); end
    end
  endtask

  task automatic test_backpressure();
    int     stall_cycles = 0;
    int     stall_bad    = 0;
    int     hold_bad     = 0;
    longint held         = 0;
    apply_reset();
    for (int c = 0; c < 80; c++) begin
      in_valid  = (accepted_beats() < 2 * ROW_BEATS);
      out_ready = (c >= 45);
      rand_ops();
      #1;
      if (out_valid && !out_ready) begin
        if (stall_cycles == 0) held = longint'(out_data);
        else if (longint'(out_data) != held) hold_bad++;
        if (in_ready !== 1'b0) stall_bad++;
        stall_cycles++;
      end
      step();
    end
    drain(2, 30);
    total++; if (stall_cycles < 20) begin bad++; $display("FAIL bp_stall_len: got %0d, required >= 20", stall_cycles); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_in_ready: got %0d cycles ready, required 0", stall_bad); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d changes, required 0", hold_bad); end
    if (exp_data.size() >= 2 && got_data.size() >= 2) begin
      total++; if (held != exp_data[0]) begin bad++; $display("FAIL bp_held_value: got %0d, required %0d", held, exp_data[0]); end
      for (int i = 0; i < 2; i++) begin
        total++; if (got_data[i] != exp_data[i] || got_idx[i] != i) begin
          bad++; $display("FAIL bp_row%0d: got %0d idx %0d, required %0d idx %0d", i, got_data[i], got_idx[i], exp_data[i], i);
        end
      end
    end
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL bp_row_count: got %0d, required 2", got_data.size()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400 && accepted_beats() < 4 * ROW_BEATS; c++) begin
      in_valid  = ($urandom_range(99) >= 30);
      out_ready = ($urandom_range(99) >= 20);
      rand_ops();
      step();
    end
    drain(4, 60);
    total++; if (got_data.size() != 4) begin bad++; $display("FAIL rand_row_count: got %0d, required 4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size() && i < exp_data.size(); i++) begin
      total++; if (got_data[i] != exp_data[i]) begin bad++; $display("FAIL rand_sum%0d: got %0d, required %0d", i, got_data[i], exp_data[i]); end
      total++; if (got_idx[i] != exp_idx[i]) begin bad++; $display("FAIL rand_idx%0d: got %0d, required %0d", i, got_idx[i], exp_idx[i]); end
    end
  endtask

  task automatic test_midrow_reset();
    apply_reset();
    // One full row plus 9 beats of the next, then reset at beat 9.
    for (int i = 0; i < ROW_BEATS + 9; i++) begin
      in_valid = 1'b1;
      rand_ops();
      step();
    end
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== '0 || out_row_idx !== '0) begin
      bad++; $display("FAIL midrst_state: got v=%b d=%0d i=%0d, required 0/0/0", out_valid, out_data, out_row_idx);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < ROW_BEATS; i++) begin
      in_valid = 1'b1;
      a_data   = {8{DATA_W'(1)}};
      b_data   = {8{DATA_W'(1)}};
      step();
    end
    drain(1, 20);
    repeat (6) step();
    total++; if (got_data.size() != 1) begin bad++; $display("FAIL midrst_rows: got %0d, required 1", got_data.size()); end
    if (got_data.size() >= 1) begin
      total++; if (got_data[0] != 128 || got_idx[0] != 0) begin
        bad++; $display("FAIL midrst_row: got %0d idx %0d, required 128 idx 0", got_data[0], got_idx[0]);
      end
    end
  endtask

  function automatic longint wrap_acc(input longint x);
    longint m = longint'(1) << OVF_ACC_W;
    longint w = x & (m - 1);
    if (w >= m / 2) w -= m;
    return w;
  endfunction

  task automatic test_overflow();
    longint acc  = 0;
    longint lo   = -(longint'(1) << (OVF_ACC_W - 1));
    longint hi   = (longint'(1) << (OVF_ACC_W - 1)) - 1;
    longint beat = 8 * 127 * 127;
    bit     sat  = 1'b0;
    bit     seen = 1'b0;
    longint got  = 0;
    int     gidx = 0;
    apply_reset();
    for (int i = 0; i < ROW_BEATS; i++) begin
`ifdef MAC8_SATURATE_EN
      if (!sat) begin
        if (acc + beat > hi) begin acc = hi; sat = 1'b1; end
        else if (acc + beat < lo) begin acc = lo; sat = 1'b1; end
        else acc = acc + beat;
      end
`else
      acc = wrap_acc(acc + beat);
`endif
    end
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b, required 0", o_ovf); end
    for (int i = 0; i < ROW_BEATS; i++) begin
      o_in_valid = 1'b1;
      o_a_data   = {8{8'd127}};
      o_b_data   = {8{8'd127}};
      @(negedge clk);
    end
    o_in_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (o_out_valid) begin
        seen = 1'b1;
        got  = longint'(o_out_data);
        gidx = int'(o_out_row_idx);
      end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL ovf_timeout: got no output, required one row"); end
    if (seen) begin
      total++; if (got != acc) begin bad++; $display("FAIL ovf_value: got %0d, required %0d", got, acc); end
      total++; if (gidx != 0) begin bad++; $display("FAIL ovf_idx: got %0d, required 0", gidx); end
    end
    total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b, required 1", o_ovf); end
    if (sat) acc = acc; // keeps sat referenced in both builds
  endtask

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a_data      = '0;
    b_data      = '0;
    o_in_valid  = 1'b0;
    o_out_ready = 1'b1;
    o_a_data    = '0;
    o_b_data    = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_random();
    test_midrow_reset();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac8_row_accumulator.md
# mac8_row_accumulator

- Downstream of the 8-wide address counter in the matrix-multiply datapath.
- Each beat, consumes the 8 operand pairs fetched at the counter's 8 addresses (Q..Q3next) and multiplies them lane-wise.
- Reduces the 8 products to one sum and accumulates it over ROW_BEATS beats.
- Emits one signed dot-product per row over a valid/ready handshake, with full backpressure.

## Interface
- DATA_W, 8: signed operand width per lane.
- ACC_W, 32: signed accumulator/result width; must be ≥ 2*DATA_W+3+clog2(ROW_BEATS).
- ROW_BEATS, 16: input beats per row (128 elements / 8 lanes).
- ROW_IDX_W, 7: width of emitted-row index.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  a_data/b_data carry one beat.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- a_data  in  8*DATA_W  lane k in bits [k*DATA_W +: DATA_W], signed.
- b_data  in  8*DATA_W  same packing as a_data.
- out_valid  out  1  out_data holds a finished row sum.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  ACC_W  signed row dot-product.
- out_row_idx  out  ROW_IDX_W  index of the row in out_data; wraps modulo 2^ROW_IDX_W.
- ovf  out  1  sticky: some accumulation exceeded the signed ACC_W range.

## Operation
- Global advance: `adv = !out_valid || out_ready`; `in_ready = adv`. All pipeline registers update only when adv=1.
- Stage P (products): 8 signed products of DATA_W×DATA_W, 2*DATA_W bits each, registered with valid vp.
- Stage S (sum): adder tree of the 8 products, sign-extended to 2*DATA_W+3 bits, registered with valid vs.
  - Beat counter is 0..ROW_BEATS-1 and increments on each accepted input beat.
  - The last flag travels with the beat and is set when the counter is ROW_BEATS-1.
- Stage A (accumulate): when vs=1, acc = (first beat of row ? 0 : acc) + sign-extended sum.
  - The first flag also travels with the beat.
  - On a last beat, the final value loads into out_data; out_valid is set and out_row_idx is loaded.
  - The accumulator restarts on the next first beat.
- Bubbles: in_valid=0 with adv=1 inserts a bubble; vp/vs clear and acc holds.
- out_valid clears on handshake unless a new last beat completes in the same cycle; in that case out_data updates and out_valid stays 1.
- Overflow: the full-precision sum is checked against the signed ACC_W range. A violation sets ovf. ovf is cleared only by reset.

## Timing
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+3, with no backpressure.
- Throughput: 1 beat/cycle; one row per ROW_BEATS cycles.
- Stall: out_valid=1 and out_ready=0 freezes all stages and deasserts in_ready the same cycle (combinational from out_valid/out_ready). No data is lost or duplicated.
- Reset (asynchronous, any time, including mid-row):
  - out_valid=0, out_data=0, out_row_idx=0, ovf=0.
  - vp=vs=0, acc=0, beat counter=0.
  - in_ready=1 after reset deasserts.
- The first beat after reset is beat 0 of row 0.
- Row index increments when a row is loaded into the output register and wraps from 2^ROW_IDX_W-1 to 0.

## Configuration
- MAC8_SATURATE_EN defined:
  - An accumulation above the max clamps acc to 2^(ACC_W-1)-1; below the min, it clamps to -2^(ACC_W-1).
  - Saturation persists for the rest of the row; ovf sets.
- Undefined: acc wraps two's-complement modulo 2^ACC_W; ovf still sets.

## Test plan
- Reset, then 16 beats with all lanes a=1, b=2, out_ready=1 → one output, out_data=256, out_row_idx=0, 3 cycles after the last beat; ovf=0.
- Signed mix: lanes a=-128, b=127 for 16 beats → out_data=-2080768 (128×-16256).
- Backpressure: out_ready=0 while row 0 completes and row 1 streams.
  - Required: in_ready=0 during the stall; row 0 holds stable.
  - After out_ready=1, rows 0 and 1 emit in order with idx 0, 1 and correct sums.
- Random in_valid gaps (about 30% bubbles) over 4 rows of random operands → sums match a reference model and idx runs 0..3.
- Reset asserted at beat 9 of a row, then a clean row of a=b=1 → out_data=128 with idx 0; no stale output.
- Overflow with ACC_W overridden to 18 and a=b=127 for 16 beats:
  - MAC8_SATURATE_EN defined → out_data=131071, ovf=1.
  - Undefined → out_data equals the wrapped value, ovf=1.
